// File: rtl/cdc_req_ack_tx.sv
// cdc_req_ack_tx: source-domain transmit side of a four-phase req/ack crossing.
//
// A word is accepted over a valid/ready interface and held on tx_data while a
// level request (tx_req) is raised. The returning acknowledge is synchronized
// and the four-phase sequence is completed before the next word is accepted:
//   IDLE --accept--> REQ --ack_s=1 (or timeout)--> ACK_LOW --ack_s=0--> IDLE
//
// Handshake: a word transfers on a rising clk edge where in_valid and in_ready
// are both 1. in_ready does not depend on in_valid. A word offered while
// in_ready is 0 is not taken, so upstream must keep it until in_ready is 1.
//
// Ports:
//   clk          source-domain clock, rising edge
//   rst          asynchronous active-high reset
//   in_data      word to send
//   in_valid     in_data valid
//   in_ready     block can accept a word (0 while rst is high)
//   tx_data      held word to the downstream synchronizer
//   tx_req       registered four-phase request level
//   tx_ack_async acknowledge from the destination domain (asynchronous)
//   err_clr      clears the sticky error flags
//   proto_err    sticky: synchronized ack seen high while IDLE
//   timeout_err  sticky: a request was aborted on timeout
//   xfer_count   completed-transfer counter, wraps at 256
module cdc_req_ack_tx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_req,
    input  logic             tx_ack_async,
    input  logic             err_clr,
    output logic             proto_err,
    output logic             timeout_err,
    output logic [7:0]       xfer_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] ACK_LOW = 2'd2;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       tx_data_q, tx_data_d;
    logic                   tx_req_q, tx_req_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   proto_err_q, proto_err_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [7:0]             xfer_count_q, xfer_count_d;
    logic [7:0]             timer_q, timer_d;
    logic                   abort_q, abort_d;

    logic ack_s;
    logic proto_set;
    logic timeout_set;

    // Only the first chain stage ever samples the asynchronous acknowledge.
    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    assign in_ready    = (state_q == IDLE) & ~rst;
    assign tx_data     = tx_data_q;
    assign tx_req      = tx_req_q;
    assign proto_err   = proto_err_q;
    assign timeout_err = timeout_err_q;
    assign xfer_count  = xfer_count_q;

    always_comb begin
        ack_sync_d    = {ack_sync_q[SYNC_STAGES-2:0], tx_ack_async};
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_req_d      = tx_req_q;
        xfer_count_d  = xfer_count_q;
        timer_d       = timer_q;
        abort_d       = abort_q;
        proto_set     = 1'b0;
        timeout_set   = 1'b0;

        case (state_q)
            IDLE: begin
                proto_set = ack_s;
                if (in_valid && in_ready) begin
                    tx_data_d = in_data;
                    tx_req_d  = 1'b1;
                    timer_d   = 8'd0;
                    abort_d   = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    state_d  = ACK_LOW;
                end else if (timer_q == TIMER_LAST) begin
                    // Abort still walks through ACK_LOW so a late ack is
                    // drained before the next word can start.
                    tx_req_d    = 1'b0;
                    timeout_set = 1'b1;
                    abort_d     = 1'b1;
                    state_d     = ACK_LOW;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ACK_LOW: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    if (!abort_q) begin
                        xfer_count_d = xfer_count_q + 8'd1;
                    end
                end
            end
            default: begin
                tx_req_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        // A new error in the same cycle as err_clr must not be lost.
        proto_err_d   = proto_set   | (proto_err_q   & ~err_clr);
        timeout_err_d = timeout_set | (timeout_err_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tx_data_q     <= '0;
            tx_req_q      <= 1'b0;
            ack_sync_q    <= '0;
            proto_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            xfer_count_q  <= 8'd0;
            timer_q       <= 8'd0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_req_q      <= tx_req_d;
            ack_sync_q    <= ack_sync_d;
            proto_err_q   <= proto_err_d;
            timeout_err_q <= timeout_err_d;
            xfer_count_q  <= xfer_count_d;
            timer_q       <= timer_d;
            abort_q       <= abort_d;
        end
    end

endmodule

// File: tb/tb_cdc_req_ack_tx.sv
module tb_cdc_req_ack_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_ack_async;
  logic       err_clr = 1'b0;
  logic       proto_err;
  logic       timeout_err;
  logic [7:0] xfer_count;

  // destination model: ack follows tx_req one cycle later when follow_en=1
  logic follow_en = 1'b1;
  logic ack_man = 1'b0;
  logic dest_ack_q;

  int checks = 0;
  int errors = 0;

  cdc_req_ack_tx #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_data(tx_data), .tx_req(tx_req),
    .tx_ack_async(tx_ack_async), .err_clr(err_clr), .proto_err(proto_err),
    .timeout_err(timeout_err), .xfer_count(xfer_count)
  );

  // ---------------- clock / reset / destination model
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) dest_ack_q <= 1'b0;
    else     dest_ack_q <= tx_req;
  end

  assign tx_ack_async = follow_en ? dest_ack_q : ack_man;

  // ---------------- driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a word, wait (bounded) for in_ready, return after the accept edge.
  task automatic accept(input logic [7:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    check("accept_ready_wait", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("req_after_accept", {31'd0, tx_req}, 32'd1);
    check("data_after_accept", {24'd0, tx_data}, {24'd0, d});
  endtask

  // Full transfer with the follow model; reports cycles with tx_req high and
  // cycles with in_ready low, both counted from the accept-edge sample.
  task automatic send_word(input logic [7:0] d, output int req_cyc, output int busy_cyc);
    int n;
    accept(d);
    req_cyc = 0;
    busy_cyc = 0;
    n = 0;
    while (!in_ready && n < 100) begin
      if (tx_req) req_cyc++;
      busy_cyc++;
      if (tx_data !== d) check("tx_data_stable", {24'd0, tx_data}, {24'd0, d});
      tick();
      n++;
    end
    check("xfer_done", {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int rc, bc, n;
    logic [7:0] exp_cnt;

    vecs[0] = '{data: 8'hAB, exp_count: 8'd1};
    vecs[1] = '{data: 8'h00, exp_count: 8'd2};
    vecs[2] = '{data: 8'hFF, exp_count: 8'd3};
    vecs[3] = '{data: 8'h5A, exp_count: 8'd4};

    // ---------------- reset state
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_tx_req", {31'd0, tx_req}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_count", {24'd0, xfer_count}, 32'd0);
    check("rst_proto", {31'd0, proto_err}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_ready", {31'd0, in_ready}, 32'd1);

    // ---------------- table-driven basic transfers
    // Accept edge 0; ack seen by model at edge 1, ack_s at edge 3, tx_req
    // drops at edge 4, ack low at 5, ack_s low at 7, IDLE at 8.
    for (int i = 0; i < 4; i++) begin
      send_word(vecs[i].data, rc, bc);
      check("basic_req_cycles", rc, 32'd4);
      check("basic_busy_cycles", bc, 32'd8);
      check("basic_count", {24'd0, xfer_count}, {24'd0, vecs[i].exp_count});
      check("basic_proto", {31'd0, proto_err}, 32'd0);
      check("basic_timeout", {31'd0, timeout_err}, 32'd0);
    end

    // ---------------- back-to-back: second word only after ACK_LOW->IDLE
    accept(8'h55);
    in_data  = 8'hDA;
    in_valid = 1'b1;
    n = 0;
    while (tx_data !== 8'hDA && n < 100) begin
      if (!in_ready) check("b2b_ready_low", {24'd0, tx_data}, 32'h55);
      if (tx_req) check("b2b_hold_req", {24'd0, tx_data}, 32'h55);
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("b2b_spacing", n, 32'd9);
    check("b2b_count_mid", {24'd0, xfer_count}, 32'd5);
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("b2b_count", {24'd0, xfer_count}, 32'd6);

    // ---------------- timeout: ack never arrives
    follow_en = 1'b0;
    ack_man   = 1'b0;
    accept(8'hFF);
    n = 0;
    while (tx_req && n < 400) begin
      check("to_data_held", {24'd0, tx_data}, 32'hFF);
      tick();
      n++;
    end
    check("to_req_cycles", n, 32'd255);
    check("to_err_set", {31'd0, timeout_err}, 32'd1);
    check("to_ready_acklow", {31'd0, in_ready}, 32'd0);
    tick();
    check("to_back_idle", {31'd0, in_ready}, 32'd1);
    check("to_count_same", {24'd0, xfer_count}, 32'd6);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_err_clr", {31'd0, timeout_err}, 32'd0);

    // ---------------- protocol error: ack high while IDLE
    ack_man = 1'b1;
    tick();
    check("pe_not_yet", {31'd0, proto_err}, 32'd0);
    tick();
    tick();
    check("pe_set", {31'd0, proto_err}, 32'd1);
    ack_man = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pe_sticky", {31'd0, proto_err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("pe_clr", {31'd0, proto_err}, 32'd0);
    ack_man = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("pe_set2", {31'd0, proto_err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("pe_set_wins", {31'd0, proto_err}, 32'd1);
    ack_man = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("pe_clr2", {31'd0, proto_err}, 32'd0);

    // ---------------- async reset mid-transfer, ack high in REQ
    accept(8'h3C);
    ack_man = 1'b1;
    tick();
    tick();
    check("rm_in_req", {31'd0, tx_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("rm_req_low", {31'd0, tx_req}, 32'd0);
    check("rm_ready_low", {31'd0, in_ready}, 32'd0);
    check("rm_count_zero", {24'd0, xfer_count}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rm_pe_not_yet", {31'd0, proto_err}, 32'd0);
    tick();
    tick();
    check("rm_pe_set", {31'd0, proto_err}, 32'd1);
    ack_man = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("rm_pe_clr", {31'd0, proto_err}, 32'd0);

    // ---------------- counter wrap
    follow_en = 1'b1;
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      send_word(8'(i * 7 + 1), rc, bc);
      exp_cnt = exp_cnt + 8'd1;
      if (i == 254) check("wrap_255", {24'd0, xfer_count}, 32'd255);
    end
    check("wrap_zero", {24'd0, xfer_count}, {24'd0, exp_cnt});
    check("wrap_zero_abs", {24'd0, xfer_count}, 32'd0);
    check("wrap_no_err", {30'd0, proto_err, timeout_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
